// File: rtl/div_unit_seq_pkg.sv
// Shared definitions for the sequential RV32M divider: op encodings, FSM states
// and the iteration count of the restoring loop.
package div_pkg;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   localparam int DIV_ITERS = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/div_unit_seq_alu.sv
// Execute-stage adder ALU: add, or subtract via inverted operand plus carry-in.
// o_carry is the adder carry-out, so in SUB mode it is set when no borrow occurs.
module div_unit_seq_alu #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic            i_sub,
   output logic [XLEN-1:0] o_sum,
   output logic            o_carry
);

   logic [XLEN-1:0] w_b;

   assign w_b = i_sub ? ~i_b : i_b;
   assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{XLEN{1'b0}}, i_sub};

endmodule

// File: rtl/div_unit_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock,
// with start/ready/done handshake and abort for pipeline flushes.
module div_unit_seq
   import div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output div_state_t      dbg_state
);

   localparam int CW = $clog2(DIV_ITERS);

   div_state_t      r_state;
   div_state_t      w_next;
   logic            r_is_rem;
   logic            r_neg_q;
   logic            r_neg_r;
   // R never exceeds D, so its 33rd bit only exists in the shifted value R'.
   logic [XLEN-1:0] r_r;
   logic [XLEN-1:0] r_q;
   logic [XLEN-1:0] r_d;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_result;

   logic            w_accept;
   logic            w_signed;
   logic [XLEN-1:0] w_abs1;
   logic [XLEN-1:0] w_abs2;
   logic            w_div0;
   logic            w_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_special_res;
   logic [XLEN:0]   w_r_prime;
   logic [XLEN-1:0] w_diff;
   logic            w_carry;
   logic            w_no_borrow;
   logic            w_last;
   logic [XLEN-1:0] w_fix_sel;
   logic            w_fix_neg;
   logic [XLEN-1:0] w_fix_res;

   assign w_accept  = start && ready && !abort;
   assign w_signed  = ~op[0];
   assign w_abs1    = (w_signed && op1[XLEN-1]) ? -op1 : op1;
   assign w_abs2    = (w_signed && op2[XLEN-1]) ? -op2 : op2;
   assign w_div0    = (op2 == '0);
   assign w_ovf     = w_signed && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
   assign w_special = w_div0 || w_ovf;

   always_comb begin
      w_special_res = '0;
      if (w_div0)
         w_special_res = op[1] ? op1 : '1;
      else
         w_special_res = op[1] ? '0 : op1;
   end

   assign w_r_prime = {r_r, r_q[XLEN-1]};

   div_unit_seq_alu #(.XLEN(XLEN)) u_alu (
      .i_a    (w_r_prime[XLEN-1:0]),
      .i_b    (r_d),
      .i_sub  (1'b1),
      .o_sum  (w_diff),
      .o_carry(w_carry)
   );

   assign w_no_borrow = w_r_prime[XLEN] | w_carry;
   assign w_last      = (r_cnt == CW'(DIV_ITERS - 1));
   assign w_fix_sel   = r_is_rem ? r_r : r_q;
   assign w_fix_neg   = r_is_rem ? r_neg_r : r_neg_q;
   assign w_fix_res   = w_fix_neg ? -w_fix_sel : w_fix_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= DIV_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = DIV_IDLE;
      end else begin
         case (r_state)
            DIV_IDLE, DIV_DONE: begin
               if (start)      w_next = w_special ? DIV_DONE : DIV_CALC;
               else            w_next = DIV_IDLE;
            end
            DIV_CALC: if (w_last) w_next = DIV_FIX;
            DIV_FIX:  w_next = DIV_DONE;
            default:  w_next = DIV_IDLE;
         endcase
      end
   end

   always_comb begin
      ready = (r_state == DIV_IDLE) || (r_state == DIV_DONE);
      busy  = (r_state == DIV_CALC) || (r_state == DIV_FIX);
      done  = (r_state == DIV_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_r      <= '0;
         r_q      <= '0;
         r_d      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_is_rem <= op[1];
         r_neg_q  <= w_signed && (op1[XLEN-1] ^ op2[XLEN-1]);
         r_neg_r  <= w_signed && op1[XLEN-1];
         r_q      <= w_abs1;
         r_d      <= w_abs2;
         r_r      <= '0;
         r_cnt    <= '0;
         if (w_special) r_result <= w_special_res;
      end else if (!abort && r_state == DIV_CALC) begin
         r_q   <= {r_q[XLEN-2:0], w_no_borrow};
         r_r   <= w_no_borrow ? w_diff : w_r_prime[XLEN-1:0];
         r_cnt <= r_cnt + 1'b1;
      end else if (!abort && r_state == DIV_FIX) begin
         r_result <= w_fix_res;
      end
   end

   assign result    = r_result;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_div_unit_seq.sv
// Directed bench for div_unit_seq: normal, signed, special-case, abort,
// mid-operation reset and back-to-back operations.
module tb_div_unit_seq;
   import div_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  op    = 2'b00;
   logic [31:0] op1   = '0;
   logic [31:0] op2   = '0;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] result;
   div_state_t  dbg_state;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res = '0;

   localparam int NORMAL_LAT  = 33;
   localparam int SPECIAL_LAT = 0;
   localparam int WAIT_LIMIT  = 40;

   div_unit_seq #(.XLEN(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .op       (op),
      .op1      (op1),
      .op2      (op2),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   // Called at a negedge; returns 1 ns after the accepting edge.
   task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      op1   = a;
      op2   = b;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts negedges after acceptance until done; returns at the done negedge.
   task automatic wait_done(input string tag, input int exp_lat);
      int n;
      logic [31:0] e;
      n = 0;
      @(negedge clk);
      if (exp_lat > 0) begin
         check({tag, "_busy"}, {31'b0, busy}, 32'd1);
         check({tag, "_ready"}, {31'b0, ready}, 32'd0);
      end
      while (!done && n < WAIT_LIMIT) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, n, exp_lat);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_res"}, result, e);
         last_res = e;
      end else begin
         check({tag, "_noexp"}, 32'd1, 32'd0);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      exp_q.push_back(exp);
      drive_start(o, a, b);
      wait_done(tag, lat);
      @(negedge clk);
      check({tag, "_pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      logic saw_done;

      repeat (2) @(negedge clk);
      check("rst_ready", {31'b0, ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_result", result, 32'h0);
      check("rst_state", 32'(dbg_state), 32'(DIV_IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, NORMAL_LAT);
      run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, NORMAL_LAT);
      run_op("div_m7_2",   DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_LAT);
      run_op("rem_m7_2",   DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_LAT);
      run_op("div_7_m2",   DIV_OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NORMAL_LAT);
      run_op("rem_7_m2",   DIV_OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, NORMAL_LAT);
      run_op("divu_max_1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORMAL_LAT);
      run_op("remu_max_10", DIV_OP_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, NORMAL_LAT);
      run_op("divu_5_0",   DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
      run_op("rem_5_0",    DIV_OP_REM,  32'd5, 32'd0, 32'd5, SPECIAL_LAT);
      run_op("div_ovf",    DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
      run_op("rem_ovf",    DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPECIAL_LAT);

      // Abort in the middle of CALC.
      drive_start(DIV_OP_DIVU, 32'd1000, 32'd10);
      saw_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw_done |= done;
      end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      saw_done |= done;
      check("abort_nodone", {31'b0, saw_done}, 32'd0);
      check("abort_ready", {31'b0, ready}, 32'd1);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_result", result, last_res);
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         saw_done |= done;
      end
      check("abort_quiet", {31'b0, saw_done}, 32'd0);
      run_op("divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, NORMAL_LAT);

      // Asynchronous reset in the middle of CALC.
      drive_start(DIV_OP_DIVU, 32'd1000, 32'd10);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_ready", {31'b0, ready}, 32'd1);
      check("mrst_busy", {31'b0, busy}, 32'd0);
      check("mrst_done", {31'b0, done}, 32'd0);
      check("mrst_result", result, 32'h0);
      check("mrst_state", 32'(dbg_state), 32'(DIV_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_after_done", {31'b0, done}, 32'd0);

      // Back-to-back: second start issued during the first DONE cycle.
      exp_q.push_back(32'd5);
      drive_start(DIV_OP_DIVU, 32'd20, 32'd4);
      wait_done("b2b_first", NORMAL_LAT);
      exp_q.push_back(32'd10);
      drive_start(DIV_OP_DIVU, 32'd50, 32'd5);
      wait_done("b2b_second", NORMAL_LAT);
      @(negedge clk);
      check("b2b_pulse", {31'b0, done}, 32'd0);
      check("b2b_hold", result, 32'd10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
